frequency_analyzer_reader: RTL and testbench
============================================

Name: frequency_analyzer_reader

Overview:
AXI4-Lite master that drains results from frequency_analyzer_manager's S00_AXI slave port.
- On a rising edge of the analyzer irq, reads REG_COUNT consecutive 32-bit registers.
- Presents each word on a valid/ready result stream.
- Optionally writes an acknowledge/clear register afterwards.
- Sits between the analyzer and the downstream consumer (DMA/packetiser), replacing CPU polling.

Parameters:
C_M00_AXI_DATA_WIDTH, 32, AXI data width; fixed at 32.
C_M00_AXI_ADDR_WIDTH, 10, AXI address width; matches the analyzer slave.
BASE_ADDR, 0, byte address of the first result register.
REG_COUNT, 6, number of registers read per trigger (1..255).
CLEAR_ENABLE, 1, 1 = issue the acknowledge write after the reads.
CLEAR_ADDR, 'h40, byte address of the acknowledge register.
CLEAR_VALUE, 1, data written to CLEAR_ADDR.

Ports:
m00_axi_aclk  in  1  clock.
m00_axi_areset  in  1  asynchronous, active-high reset.
irq  in  1  analyzer interrupt, synchronous to m00_axi_aclk.
busy  out  1  high while a read sequence is in progress.
error  out  1  sticky; set on any non-OKAY rresp/bresp, cleared at the next sequence start.
result_data  out  32  register word.
result_index  out  8  register ordinal 0..REG_COUNT-1.
result_last  out  1  high with index REG_COUNT-1.
result_valid  out  1  stream valid.
result_ready  in  1  stream ready.
m00_axi_araddr  out  ADDR_WIDTH  read address.
m00_axi_arprot  out  3  constant 3'b000.
m00_axi_arvalid  out  1  read address valid.
m00_axi_arready  in  1  read address ready.
m00_axi_rdata  in  32  read data.
m00_axi_rresp  in  2  read response.
m00_axi_rvalid  in  1  read data valid.
m00_axi_rready  out  1  read data ready.
m00_axi_awaddr  out  ADDR_WIDTH  write address.
m00_axi_awprot  out  3  constant 3'b000.
m00_axi_awvalid  out  1  write address valid.
m00_axi_awready  in  1  write address ready.
m00_axi_wdata  out  32  write data.
m00_axi_wstrb  out  4  constant 4'hF.
m00_axi_wvalid  out  1  write data valid.
m00_axi_wready  in  1  write data ready.
m00_axi_bresp  in  2  write response.
m00_axi_bvalid  in  1  write response valid.
m00_axi_bready  out  1  write response ready.

Behaviour:
- Reset (async, immediate): every output 0, addresses 0, state IDLE, pending 0. Reset mid-transaction abandons the transaction; the system resets the slave in the same domain.
- Trigger: irq registered once; trigger = irq & ~irq_q. A trigger while busy sets a one-deep pending flag; further triggers while pending are dropped.
- States and transitions:
  - IDLE: on trigger or pending, clear pending, clear error, idx<=0, busy<=1, go to AR.
  - AR: arvalid=1, araddr=BASE_ADDR+4*idx. On arready, arvalid<=0 and go to R. araddr stays stable while arvalid is high.
  - R: rready=1. On rvalid, latch rdata into result_data; if rresp!=OKAY set error. Go to OUT.
  - OUT: result_valid=1 with result_index=idx and result_last=(idx==REG_COUNT-1). On result_ready:
    - not last: idx++ and go to AR;
    - last with CLEAR_ENABLE: go to WR;
    - last without CLEAR_ENABLE: go to IDLE.
    The word is held stable while result_valid is high.
  - WR: awvalid and wvalid both 1; each drops independently when its ready is seen (either order, or the same cycle). When both are done, go to B.
  - B: bready=1. On bvalid, if bresp!=OKAY set error; go to IDLE.
  - On return to IDLE, busy<=0. If pending is set, the next sequence starts in the following cycle.
- Exactly one outstanding AXI transaction at a time; no read/write overlap.
- Latency with an always-ready slave and sink: arvalid rises 1 cycle after the trigger cycle; result_valid rises 2 cycles after the AR handshake.
- Error (SLVERR/DECERR) does not abort the sequence; the word is still delivered.
- Address arithmetic is modulo 2^ADDR_WIDTH.

Decomposition:
- Shared package holds:
  - state enum {IDLE, AR, R, OUT, WR, B};
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - WSTRB_ALL=4'hF.
- No sub-module required; the irq edge detector stays inline.

Test Plan:
- AXI slave model with always-ready; registers 0x0..0x14 = 0x11..0x66; irq pulse -> 6 stream beats with data 0x11..0x66, index 0..5, last only on 5; then one write of 1 to 0x40; busy drops after bvalid.
- Random arready/rvalid/result_ready stalls (0-5 cycles) -> identical beat sequence; araddr/arvalid and result_* stable while stalled.
- awready 3 cycles before wready, and the reverse order -> exactly one AW and one W handshake each; bready asserted only after both.
- rresp=SLVERR on index 2 -> all 6 beats delivered; error=1 after the sequence; cleared when the next trigger starts.
- Two irq edges during a busy sequence -> exactly one additional sequence follows (12 beats total).
- Assert m00_axi_areset while in R state -> all outputs 0 in the same cycle; the next irq yields a clean 6-beat sequence.

Source files
------------

// File: rtl/frequency_analyzer_reader_pkg.sv
// Shared types and AXI constants for the frequency analyzer result reader.
package frequency_analyzer_reader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        AR,
        R,
        OUT,
        WR,
        B
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [3:0] WSTRB_ALL = 4'hF;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/frequency_analyzer_reader.sv
// AXI4-Lite master: on irq rising edge reads REG_COUNT result words and streams them out, then acks.
// Latency: arvalid 1 cycle after trigger cycle; result_valid 2 cycles after each AR handshake.
// Backpressure: one AXI transaction outstanding; the stream word is held until result_ready.
module frequency_analyzer_reader #(
    parameter int                                C_M00_AXI_DATA_WIDTH = 32,
    parameter int                                C_M00_AXI_ADDR_WIDTH = 10,
    parameter logic [C_M00_AXI_ADDR_WIDTH-1:0]   BASE_ADDR            = '0,
    parameter int                                REG_COUNT            = 6,
    parameter bit                                CLEAR_ENABLE         = 1'b1,
    parameter logic [C_M00_AXI_ADDR_WIDTH-1:0]   CLEAR_ADDR           = 'h40,
    parameter logic [C_M00_AXI_DATA_WIDTH-1:0]   CLEAR_VALUE          = 1
) (
    input  logic                              m00_axi_aclk,
    input  logic                              m00_axi_areset,
    input  logic                              irq,
    output logic                              busy,
    output logic                              error,
    output logic [C_M00_AXI_DATA_WIDTH-1:0]   result_data,
    output logic [7:0]                        result_index,
    output logic                              result_last,
    output logic                              result_valid,
    input  logic                              result_ready,
    output logic [C_M00_AXI_ADDR_WIDTH-1:0]   m00_axi_araddr,
    output logic [2:0]                        m00_axi_arprot,
    output logic                              m00_axi_arvalid,
    input  logic                              m00_axi_arready,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0]   m00_axi_rdata,
    input  logic [1:0]                        m00_axi_rresp,
    input  logic                              m00_axi_rvalid,
    output logic                              m00_axi_rready,
    output logic [C_M00_AXI_ADDR_WIDTH-1:0]   m00_axi_awaddr,
    output logic [2:0]                        m00_axi_awprot,
    output logic                              m00_axi_awvalid,
    input  logic                              m00_axi_awready,
    output logic [C_M00_AXI_DATA_WIDTH-1:0]   m00_axi_wdata,
    output logic [C_M00_AXI_DATA_WIDTH/8-1:0] m00_axi_wstrb,
    output logic                              m00_axi_wvalid,
    input  logic                              m00_axi_wready,
    input  logic [1:0]                        m00_axi_bresp,
    input  logic                              m00_axi_bvalid,
    output logic                              m00_axi_bready
);
    import frequency_analyzer_reader_pkg::*;

    localparam int AW = C_M00_AXI_ADDR_WIDTH;
    localparam int DW = C_M00_AXI_DATA_WIDTH;
    localparam logic [7:0] LAST_IDX = 8'(REG_COUNT - 1);

    state_t          state_q, state_d;
    logic            irq_q;
    logic            pending_q, pending_d;
    logic [7:0]      idx_q, idx_d;
    logic            busy_q, busy_d;
    logic            error_q, error_d;
    logic [DW-1:0]   result_data_q, result_data_d;
    logic [7:0]      result_index_q, result_index_d;
    logic            result_last_q, result_last_d;
    logic            result_valid_q, result_valid_d;
    logic [AW-1:0]   araddr_q, araddr_d;
    logic            arvalid_q, arvalid_d;
    logic            rready_q, rready_d;
    logic [AW-1:0]   awaddr_q, awaddr_d;
    logic            awvalid_q, awvalid_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            wvalid_q, wvalid_d;
    logic            bready_q, bready_d;
    logic            trigger;

    // Word address of register idx, wrapping modulo the address space.
    function automatic logic [AW-1:0] reg_addr(input logic [7:0] idx);
        logic [AW-1:0] offset;
        offset = AW'({idx, 2'b00});
        return BASE_ADDR + offset;
    endfunction

    assign trigger = irq & ~irq_q;

    always_comb begin
        state_d        = state_q;
        pending_d      = pending_q;
        idx_d          = idx_q;
        busy_d         = busy_q;
        error_d        = error_q;
        result_data_d  = result_data_q;
        result_index_d = result_index_q;
        result_last_d  = result_last_q;
        result_valid_d = result_valid_q;
        araddr_d       = araddr_q;
        arvalid_d      = arvalid_q;
        rready_d       = rready_q;
        awaddr_d       = awaddr_q;
        awvalid_d      = awvalid_q;
        wdata_d        = wdata_q;
        wvalid_d       = wvalid_q;
        bready_d       = bready_q;

        if (trigger && state_q != IDLE) begin
            pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (trigger || pending_q) begin
                    // A fresh edge landing together with a pending one stays queued.
                    pending_d = trigger && pending_q;
                    error_d   = 1'b0;
                    idx_d     = 8'd0;
                    busy_d    = 1'b1;
                    araddr_d  = reg_addr(8'd0);
                    arvalid_d = 1'b1;
                    state_d   = AR;
                end
            end
            AR: begin
                if (m00_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = R;
                end
            end
            R: begin
                if (m00_axi_rvalid) begin
                    rready_d       = 1'b0;
                    result_data_d  = m00_axi_rdata;
                    result_index_d = idx_q;
                    result_last_d  = (idx_q == LAST_IDX);
                    result_valid_d = 1'b1;
                    if (resp_is_err(m00_axi_rresp)) begin
                        error_d = 1'b1;
                    end
                    state_d = OUT;
                end
            end
            OUT: begin
                if (result_ready) begin
                    result_valid_d = 1'b0;
                    if (!result_last_q) begin
                        idx_d     = idx_q + 8'd1;
                        araddr_d  = reg_addr(idx_q + 8'd1);
                        arvalid_d = 1'b1;
                        state_d   = AR;
                    end else if (CLEAR_ENABLE) begin
                        awaddr_d  = CLEAR_ADDR;
                        wdata_d   = CLEAR_VALUE;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            WR: begin
                if (m00_axi_awready) begin
                    awvalid_d = 1'b0;
                end
                if (m00_axi_wready) begin
                    wvalid_d = 1'b0;
                end
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = B;
                end
            end
            B: begin
                if (m00_axi_bvalid) begin
                    bready_d = 1'b0;
                    busy_d   = 1'b0;
                    if (resp_is_err(m00_axi_bresp)) begin
                        error_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge m00_axi_aclk or posedge m00_axi_areset) begin
        if (m00_axi_areset) begin
            state_q        <= IDLE;
            irq_q          <= 1'b0;
            pending_q      <= 1'b0;
            idx_q          <= '0;
            busy_q         <= 1'b0;
            error_q        <= 1'b0;
            result_data_q  <= '0;
            result_index_q <= '0;
            result_last_q  <= 1'b0;
            result_valid_q <= 1'b0;
            araddr_q       <= '0;
            arvalid_q      <= 1'b0;
            rready_q       <= 1'b0;
            awaddr_q       <= '0;
            awvalid_q      <= 1'b0;
            wdata_q        <= '0;
            wvalid_q       <= 1'b0;
            bready_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            irq_q          <= irq;
            pending_q      <= pending_d;
            idx_q          <= idx_d;
            busy_q         <= busy_d;
            error_q        <= error_d;
            result_data_q  <= result_data_d;
            result_index_q <= result_index_d;
            result_last_q  <= result_last_d;
            result_valid_q <= result_valid_d;
            araddr_q       <= araddr_d;
            arvalid_q      <= arvalid_d;
            rready_q       <= rready_d;
            awaddr_q       <= awaddr_d;
            awvalid_q      <= awvalid_d;
            wdata_q        <= wdata_d;
            wvalid_q       <= wvalid_d;
            bready_q       <= bready_d;
        end
    end

    assign busy            = busy_q;
    assign error           = error_q;
    assign result_data     = result_data_q;
    assign result_index    = result_index_q;
    assign result_last     = result_last_q;
    assign result_valid    = result_valid_q;
    assign m00_axi_araddr  = araddr_q;
    assign m00_axi_arprot  = 3'b000;
    assign m00_axi_arvalid = arvalid_q;
    assign m00_axi_rready  = rready_q;
    assign m00_axi_awaddr  = awaddr_q;
    assign m00_axi_awprot  = 3'b000;
    assign m00_axi_awvalid = awvalid_q;
    assign m00_axi_wdata   = wdata_q;
    assign m00_axi_wstrb   = WSTRB_ALL;
    assign m00_axi_wvalid  = wvalid_q;
    assign m00_axi_bready  = bready_q;

endmodule

// File: tb/tb_frequency_analyzer_reader.sv
// Directed bench for frequency_analyzer_reader: AXI4-Lite slave model with optional stalls,
// stream sink, and hand-computed expectations for each step.
module tb_frequency_analyzer_reader;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          areset = 1'b1;
    logic          irq = 1'b0;
    logic          busy, error;
    logic [31:0]   result_data;
    logic [7:0]    result_index;
    logic          result_last, result_valid;
    logic          result_ready = 1'b0;
    logic [AW-1:0] araddr, awaddr;
    logic [2:0]    arprot, awprot;
    logic          arvalid, rready, awvalid, wvalid, bready;
    logic          arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic [31:0]   rdata = '0, wdata;
    logic [1:0]    rresp = '0, bresp = '0;
    logic [3:0]    wstrb;

    frequency_analyzer_reader dut (
        .m00_axi_aclk(clk), .m00_axi_areset(areset), .irq(irq),
        .busy(busy), .error(error),
        .result_data(result_data), .result_index(result_index), .result_last(result_last),
        .result_valid(result_valid), .result_ready(result_ready),
        .m00_axi_araddr(araddr), .m00_axi_arprot(arprot), .m00_axi_arvalid(arvalid),
        .m00_axi_arready(arready), .m00_axi_rdata(rdata), .m00_axi_rresp(rresp),
        .m00_axi_rvalid(rvalid), .m00_axi_rready(rready),
        .m00_axi_awaddr(awaddr), .m00_axi_awprot(awprot), .m00_axi_awvalid(awvalid),
        .m00_axi_awready(awready), .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb),
        .m00_axi_wvalid(wvalid), .m00_axi_wready(wready),
        .m00_axi_bresp(bresp), .m00_axi_bvalid(bvalid), .m00_axi_bready(bready)
    );

    always #5 clk = ~clk;

    // Stimulus knobs, written only by the main sequence.
    bit stall_en = 1'b0;
    bit r_hold   = 1'b0;
    int aw_dly   = 0;
    int w_dly    = 0;
    int err_idx  = -1;

    // Slave and sink model state.
    bit            rd_busy = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    int            ar_wait = 0, r_wait = 0, sink_wait = 0, aw_cnt = 0, w_cnt = 0;
    bit            aw_got = 1'b0, w_got = 1'b0;

    // Monitor results.
    int            beat_cnt = 0, aw_hs = 0, w_hs = 0, b_hs = 0, bready_early = 0, stab_viol = 0;
    logic [40:0]   beat_log [0:127];
    logic [AW-1:0] aw_addr_seen = '0;
    logic [31:0]   w_data_seen = '0;
    logic [3:0]    w_strb_seen = '0;
    bit            prev_ar_stall = 1'b0, prev_out_stall = 1'b0;
    logic [AW-1:0] prev_araddr = '0;
    logic [40:0]   prev_word = '0;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        int i;
        i = int'(a) >> 2;
        return (i < 6) ? 32'(32'h11 * (i + 1)) : 32'hDEAD_BEEF;
    endfunction

    always @(posedge clk) begin
        if (areset) begin
            rd_busy = 1'b0; aw_got = 1'b0; w_got = 1'b0; aw_cnt = 0; w_cnt = 0;
            ar_wait = 0; r_wait = 0; sink_wait = 0; prev_ar_stall = 1'b0; prev_out_stall = 1'b0;
        end else begin
            if (prev_ar_stall && (!arvalid || araddr != prev_araddr)) stab_viol++;
            if (prev_out_stall && (!result_valid || {result_data, result_index, result_last} != prev_word))
                stab_viol++;
            prev_ar_stall  = arvalid && !arready;
            prev_araddr    = araddr;
            prev_out_stall = result_valid && !result_ready;
            prev_word      = {result_data, result_index, result_last};
            if (rvalid && rready) rd_busy = 1'b0;
            if (arvalid && arready) begin
                rd_busy = 1'b1;
                rd_addr = araddr;
                ar_wait = stall_en ? int'($urandom_range(0, 5)) : 0;
                r_wait  = stall_en ? int'($urandom_range(0, 5)) : 0;
            end
            if (result_valid && result_ready) begin
                if (beat_cnt < 128) beat_log[beat_cnt] = {result_data, result_index, result_last};
                beat_cnt++;
                sink_wait = stall_en ? int'($urandom_range(0, 5)) : 0;
            end
            if (bready && !(aw_got && w_got)) bready_early++;
            if (bvalid && bready) begin
                b_hs++; aw_got = 1'b0; w_got = 1'b0; aw_cnt = 0; w_cnt = 0;
            end
            if (awvalid && awready) begin
                aw_hs++; aw_got = 1'b1; aw_addr_seen = awaddr;
            end
            if (wvalid && wready) begin
                w_hs++; w_got = 1'b1; w_data_seen = wdata; w_strb_seen = wstrb;
            end
        end
    end

    always @(negedge clk) begin
        if (areset) begin
            arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; result_ready = 1'b0;
            awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0;
        end else begin
            if (arvalid && !rd_busy) begin
                if (ar_wait > 0) begin ar_wait--; arready = 1'b0; end
                else arready = 1'b1;
            end else arready = 1'b0;
            if (rd_busy && !r_hold) begin
                if (r_wait > 0) begin r_wait--; rvalid = 1'b0; end
                else begin
                    rvalid = 1'b1;
                    rdata  = mem_word(rd_addr);
                    rresp  = (int'(rd_addr) == err_idx * 4) ? 2'b10 : 2'b00;
                end
            end else rvalid = 1'b0;
            if (result_valid && sink_wait > 0) begin sink_wait--; result_ready = 1'b0; end
            else result_ready = 1'b1;
            if (awvalid && !aw_got) begin
                if (aw_cnt < aw_dly) begin aw_cnt++; awready = 1'b0; end
                else awready = 1'b1;
            end else awready = 1'b0;
            if (wvalid && !w_got) begin
                if (w_cnt < w_dly) begin w_cnt++; wready = 1'b0; end
                else wready = 1'b1;
            end else wready = 1'b0;
            bvalid = aw_got && w_got;
            bresp  = 2'b00;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_irq();
        irq = 1'b1;
        tick(1);
        irq = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n;
        n = 0;
        while (busy && n < max) begin tick(1); n++; end
        check(tag, 64'(busy), 64'd0);
    endtask

    task automatic check_beats(input string tag, input int base, input int n);
        logic [40:0] exp;
        check({tag, "_count"}, 64'(beat_cnt - base), 64'(n));
        for (int i = 0; i < n; i++) begin
            int k;
            k = i % 6;
            exp = {32'(32'h11 * (k + 1)), 8'(k), (k == 5)};
            check($sformatf("%s_beat%0d", tag, i), 64'(beat_log[base + i]), 64'(exp));
        end
    endtask

    initial begin
        int base, aw0, w0, b0, n;

        // Reset state
        tick(3);
        check("rst_ctrl", 64'({busy, error, arvalid, rready, result_valid, result_last, awvalid, wvalid, bready}), 64'd0);
        check("rst_addr", 64'({araddr, awaddr}), 64'd0);
        check("rst_data", 64'({result_data, result_index}), 64'd0);
        check("prot_strb", 64'({arprot, awprot, wstrb}), 64'h00F);
        areset = 1'b0;
        tick(2);

        // Basic sequence with latency checks
        base = beat_cnt; aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
        irq = 1'b1;
        check("pre_trig_arvalid", 64'(arvalid), 64'd0);
        tick(1);
        irq = 1'b0;
        check("lat_arvalid", 64'({busy, arvalid}), 64'h3);
        check("lat_araddr", 64'(araddr), 64'h0);
        tick(1);
        check("ar_hs_state", 64'({arvalid, rready, result_valid}), 64'b010);
        tick(1);
        check("lat_result", 64'({result_valid, result_data}), 64'h1_0000_0011);
        wait_idle("t1_idle", 200);
        check_beats("t1", base, 6);
        check("t1_aw", 64'(aw_hs - aw0), 64'd1);
        check("t1_w", 64'(w_hs - w0), 64'd1);
        check("t1_b", 64'(b_hs - b0), 64'd1);
        check("t1_clr_addr", 64'(aw_addr_seen), 64'h40);
        check("t1_clr_data", 64'({w_strb_seen, w_data_seen}), 64'hF_0000_0001);
        check("t1_error", 64'(error), 64'd0);

        // Random stalls on AR, R and stream ready
        stall_en = 1'b1;
        for (int r = 0; r < 3; r++) begin
            base = beat_cnt;
            pulse_irq();
            wait_idle("t2_idle", 2000);
            check_beats("t2", base, 6);
        end
        stall_en = 1'b0;
        tick(2);

        // AW accepted before W, then W before AW
        for (int r = 0; r < 2; r++) begin
            aw_dly = (r == 0) ? 0 : 3;
            w_dly  = (r == 0) ? 3 : 0;
            aw0 = aw_hs; w0 = w_hs; b0 = b_hs; base = beat_cnt;
            pulse_irq();
            wait_idle("t3_idle", 300);
            check_beats("t3", base, 6);
            check($sformatf("t3_aw_once%0d", r), 64'(aw_hs - aw0), 64'd1);
            check($sformatf("t3_w_once%0d", r), 64'(w_hs - w0), 64'd1);
            check($sformatf("t3_b_once%0d", r), 64'(b_hs - b0), 64'd1);
        end
        aw_dly = 0; w_dly = 0;
        tick(2);

        // SLVERR on index 2
        err_idx = 2;
        base = beat_cnt;
        pulse_irq();
        wait_idle("t4_idle", 300);
        check_beats("t4", base, 6);
        check("t4_error_set", 64'(error), 64'd1);
        err_idx = -1;
        tick(2);
        check("t4_error_sticky", 64'(error), 64'd1);
        pulse_irq();
        check("t4_error_clr", 64'({busy, error}), 64'b10);
        wait_idle("t4b_idle", 300);
        check("t4_error_after", 64'(error), 64'd0);
        tick(2);

        // Two extra edges while busy: exactly one more sequence
        base = beat_cnt;
        pulse_irq();
        tick(3);
        pulse_irq();
        tick(3);
        pulse_irq();
        n = 0;
        while (beat_cnt - base < 12 && n < 400) begin tick(1); n++; end
        wait_idle("t5_idle", 300);
        tick(30);
        check("t5_quiet", 64'(busy), 64'd0);
        check_beats("t5", base, 12);

        // Reset while waiting for read data
        r_hold = 1'b1;
        pulse_irq();
        n = 0;
        while (!rready && n < 20) begin tick(1); n++; end
        check("t6_in_r", 64'(rready), 64'd1);
        #2 areset = 1'b1;
        #1;
        check("t6_rst_ctrl", 64'({busy, error, arvalid, rready, result_valid, result_last, awvalid, wvalid, bready}), 64'd0);
        check("t6_rst_addr", 64'({araddr, awaddr}), 64'd0);
        check("t6_rst_data", 64'({result_data, result_index}), 64'd0);
        tick(2);
        areset = 1'b0;
        r_hold = 1'b0;
        tick(2);
        base = beat_cnt;
        pulse_irq();
        wait_idle("t6_idle", 300);
        check_beats("t6", base, 6);
        check("t6_error", 64'(error), 64'd0);

        check("stable_while_stalled", 64'(stab_viol), 64'd0);
        check("bready_after_aw_w", 64'(bready_early), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
